// File: rtl/snake_pkg.sv
// Shared definitions for the snake step engine.
// Holds the direction encoding, default playfield and length limits, start
// position, FSM state type and the reversal-filter helper.
package snake_pkg;

  localparam int GRID_W_DEF  = 40;
  localparam int GRID_H_DEF  = 30;
  localparam int MAX_LEN_DEF = 16;

  localparam int X_W   = 6;
  localparam int Y_W   = 5;
  localparam int LEN_W = 5;
  localparam int IDX_W = 4;

  localparam logic [X_W-1:0]   START_X   = 6'd20;
  localparam logic [Y_W-1:0]   START_Y   = 5'd15;
  localparam logic [LEN_W-1:0] START_LEN = 5'd3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DEAD   = 3'd4
  } state_e;

  // Opposite directions differ only in bit 1, so a reversal request is
  // recognised by flipping that bit of the current heading.
  function automatic dir_e eff_dir(input dir_e cur, input dir_e req);
    dir_e res;
    if (req == dir_e'(cur ^ 2'b10)) begin
      res = cur;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator.
// Ports: head_x/head_y current head, dir heading; next_x/next_y candidate
// head (truncated), oob set when the candidate leaves the playfield.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic [X_W-1:0] head_x,
  input  logic [Y_W-1:0] head_y,
  input  dir_e           dir,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y,
  output logic           oob
);

  localparam logic [X_W:0] X_LIM = (X_W+1)'(GRID_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(GRID_H);

  logic [X_W:0] ext_x_s;
  logic [Y_W:0] ext_y_s;

  // One extra bit makes 0-1 become all ones, which lands above the limit
  // instead of wrapping to a legal coordinate.
  always_comb begin
    ext_x_s = {1'b0, head_x};
    ext_y_s = {1'b0, head_y};
    case (dir)
      DIR_UP:    ext_y_s = {1'b0, head_y} - (Y_W+1)'(1);
      DIR_RIGHT: ext_x_s = {1'b0, head_x} + (X_W+1)'(1);
      DIR_DOWN:  ext_y_s = {1'b0, head_y} + (Y_W+1)'(1);
      DIR_LEFT:  ext_x_s = {1'b0, head_x} - (X_W+1)'(1);
      default: begin
        ext_x_s = {1'b0, head_x};
        ext_y_s = {1'b0, head_y};
      end
    endcase
    next_x = ext_x_s[X_W-1:0];
    next_y = ext_y_s[Y_W-1:0];
    oob    = (ext_x_s >= X_LIM) || (ext_y_s >= Y_LIM);
  end

endmodule

// File: rtl/snake_step.sv
// Snake game step engine: on a tick it computes the next head, checks walls
// and self-collision one segment per cycle, then shifts the body in one go.
// Inputs: iClock, iReset (sync, active-high), iTick, iDir, iFoodX/iFoodY,
// iRdIdx. Outputs: oSegX/oSegY (segment at iRdIdx), oHeadX/oHeadY, oLength,
// oBusy, oStepDone, oAte, oDead (sticky).
module snake_step
  import snake_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iTick,
  input  logic [1:0]       iDir,
  input  logic [X_W-1:0]   iFoodX,
  input  logic [Y_W-1:0]   iFoodY,
  input  logic [IDX_W-1:0] iRdIdx,
  output logic [X_W-1:0]   oSegX,
  output logic [Y_W-1:0]   oSegY,
  output logic [X_W-1:0]   oHeadX,
  output logic [Y_W-1:0]   oHeadY,
  output logic [LEN_W-1:0] oLength,
  output logic             oBusy,
  output logic             oStepDone,
  output logic             oAte,
  output logic             oDead
);

  state_e             state_r, state_s;
  dir_e               dir_r, eff_dir_s;
  logic [X_W-1:0]     seg_x_r [MAX_LEN];
  logic [Y_W-1:0]     seg_y_r [MAX_LEN];
  logic [LEN_W-1:0]   len_r;
  logic [X_W-1:0]     nxt_x_r, calc_x_s;
  logic [Y_W-1:0]     nxt_y_r, calc_y_s;
  logic               calc_oob_s, calc_eat_s, calc_grow_s;
  logic               eat_r, grow_r;
  logic [IDX_W-1:0]   scan_idx_r, scan_last_r;
  logic [LEN_W-1:0]   scan_last_s;
  logic               scan_hit_s;
  logic               busy_r, step_done_r, ate_r, dead_r;

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .head_x (seg_x_r[0]),
    .head_y (seg_y_r[0]),
    .dir    (dir_r),
    .next_x (calc_x_s),
    .next_y (calc_y_s),
    .oob    (calc_oob_s)
  );

  assign eff_dir_s   = eff_dir(dir_r, dir_e'(iDir));
  assign calc_eat_s  = (calc_x_s == iFoodX) && (calc_y_s == iFoodY);
  assign calc_grow_s = calc_eat_s && (len_r < LEN_W'(MAX_LEN));
  // When growing the tail stays put, so it must be included in the scan.
  assign scan_last_s = calc_grow_s ? (len_r - 5'd1) : (len_r - 5'd2);
  assign scan_hit_s  = (seg_x_r[scan_idx_r] == nxt_x_r) &&
                       (seg_y_r[scan_idx_r] == nxt_y_r);

  assign oSegX     = seg_x_r[iRdIdx];
  assign oSegY     = seg_y_r[iRdIdx];
  assign oHeadX    = seg_x_r[0];
  assign oHeadY    = seg_y_r[0];
  assign oLength   = len_r;
  assign oBusy     = busy_r;
  assign oStepDone = step_done_r;
  assign oAte      = ate_r;
  assign oDead     = dead_r;

  // Next-state decision.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iTick) state_s = ST_CALC;
        else       state_s = ST_IDLE;
      end
      ST_CALC: begin
        if (calc_oob_s)                          state_s = ST_DEAD;
        else if (!calc_grow_s && len_r == 5'd1) state_s = ST_COMMIT;
        else                                     state_s = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_hit_s)                       state_s = ST_DEAD;
        else if (scan_idx_r == scan_last_r)   state_s = ST_COMMIT;
        else                                  state_s = ST_SCAN;
      end
      ST_COMMIT: state_s = ST_IDLE;
      ST_DEAD:   state_s = ST_DEAD;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_r     <= ST_IDLE;
      dir_r       <= DIR_RIGHT;
      len_r       <= START_LEN;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= '0;
        seg_y_r[i] <= '0;
      end
      seg_x_r[0]  <= START_X;
      seg_x_r[1]  <= START_X - 6'd1;
      seg_x_r[2]  <= START_X - 6'd2;
      seg_y_r[0]  <= START_Y;
      seg_y_r[1]  <= START_Y;
      seg_y_r[2]  <= START_Y;
      nxt_x_r     <= '0;
      nxt_y_r     <= '0;
      eat_r       <= 1'b0;
      grow_r      <= 1'b0;
      scan_idx_r  <= '0;
      scan_last_r <= '0;
      busy_r      <= 1'b0;
      step_done_r <= 1'b0;
      ate_r       <= 1'b0;
      dead_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (iTick) dir_r <= eff_dir_s;
        end
        ST_CALC: begin
          nxt_x_r     <= calc_x_s;
          nxt_y_r     <= calc_y_s;
          eat_r       <= calc_eat_s;
          grow_r      <= calc_grow_s;
          scan_idx_r  <= '0;
          scan_last_r <= scan_last_s[IDX_W-1:0];
        end
        ST_SCAN: scan_idx_r <= scan_idx_r + 4'd1;
        ST_COMMIT: begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x_r[i] <= seg_x_r[i-1];
            seg_y_r[i] <= seg_y_r[i-1];
          end
          seg_x_r[0] <= nxt_x_r;
          seg_y_r[0] <= nxt_y_r;
          if (grow_r) len_r <= len_r + 5'd1;
        end
        default: ;
      endcase
      // Pulses appear the cycle after COMMIT, when the new body is visible.
      step_done_r <= (state_r == ST_COMMIT);
      ate_r       <= (state_r == ST_COMMIT) && eat_r;
      busy_r      <= (state_s == ST_CALC) || (state_s == ST_SCAN) ||
                     (state_s == ST_COMMIT);
      dead_r      <= (state_s == ST_DEAD);
    end
  end

endmodule

// File: tb/tb_snake_step.sv
module tb_snake_step;
  logic       iClock = 1'b0;
  logic       iReset, iTick;
  logic [1:0] iDir;
  logic [5:0] iFoodX, oSegX, oHeadX;
  logic [4:0] iFoodY, oSegY, oHeadY, oLength;
  logic [3:0] iRdIdx;
  logic       oBusy, oStepDone, oAte, oDead;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 iClock = ~iClock;

  snake_step dut (
    .iClock(iClock), .iReset(iReset), .iTick(iTick), .iDir(iDir),
    .iFoodX(iFoodX), .iFoodY(iFoodY), .iRdIdx(iRdIdx),
    .oSegX(oSegX), .oSegY(oSegY), .oHeadX(oHeadX), .oHeadY(oHeadY),
    .oLength(oLength), .oBusy(oBusy), .oStepDone(oStepDone),
    .oAte(oAte), .oDead(oDead)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_seg(input string tag, input int idx, input int x, input int y);
    iRdIdx = 4'(idx);
    #1;
    check({tag, "_x"}, int'(oSegX), x);
    check({tag, "_y"}, int'(oSegY), y);
  endtask

  // Tick in cycle 0; lat = cycle index where oStepDone is seen (0 if none).
  task automatic do_step(input logic [1:0] dir, input bit extra,
                         output int lat, output bit dead, output bit ate,
                         output bit busy1);
    bit fin;
    lat = 0; dead = 1'b0; ate = 1'b0; busy1 = 1'b0; fin = 1'b0;
    @(posedge iClock); #1;
    iDir = dir; iTick = 1'b1;
    for (int k = 1; k <= 40 && !fin; k++) begin
      @(posedge iClock); #1;
      iTick = (extra && k == 2);
      @(negedge iClock);
      if (k == 1) busy1 = oBusy;
      if (oStepDone) begin
        lat = k; ate = oAte; fin = 1'b1;
      end else if (oDead) begin
        dead = 1'b1; fin = 1'b1;
      end
    end
    iTick = 1'b0;
  endtask

  task automatic do_reset();
    iReset = 1'b1;
    repeat (2) @(posedge iClock);
    #1 iReset = 1'b0;
    @(negedge iClock);
  endtask

  initial begin
    int lat, cnt;
    bit dead, ate, busy1;
    iReset = 1'b1; iTick = 1'b0; iDir = 2'b01;
    iFoodX = 6'd0; iFoodY = 5'd0; iRdIdx = 4'd0;
    do_reset();

    // Reset state
    check("rst_len", int'(oLength), 3);
    check("rst_hx", int'(oHeadX), 20);
    check("rst_hy", int'(oHeadY), 15);
    check("rst_flags", {oDead, oBusy, oStepDone, oAte}, 0);
    check_seg("rst_seg1", 1, 19, 15);
    check_seg("rst_seg2", 2, 18, 15);

    // Plain step right: latency 3+2
    do_step(2'b01, 1'b0, lat, dead, ate, busy1);
    check("s1_lat", lat, 5);
    check("s1_busy", busy1, 1);
    check("s1_ate", ate, 0);
    check("s1_hx", int'(oHeadX), 21);
    check("s1_len", int'(oLength), 3);
    check_seg("s1_seg2", 2, 19, 15);

    // Reversal request ignored
    do_step(2'b11, 1'b0, lat, dead, ate, busy1);
    check("rev_lat", lat, 5);
    check("rev_hx", int'(oHeadX), 22);
    check("rev_hy", int'(oHeadY), 15);

    // Eat: grows, scan covers 3 segments
    iFoodX = 6'd23; iFoodY = 5'd15;
    do_step(2'b01, 1'b0, lat, dead, ate, busy1);
    check("eat_lat", lat, 6);
    check("eat_ate", ate, 1);
    check("eat_len", int'(oLength), 4);
    check_seg("eat_seg3", 3, 20, 15);
    @(negedge iClock);
    check("eat_pulse1", {oAte, oStepDone}, 0);
    iFoodX = 6'd0; iFoodY = 5'd0;

    // Tick during busy is ignored
    do_step(2'b01, 1'b1, lat, dead, ate, busy1);
    check("busy_lat", lat, 6);
    cnt = 0;
    repeat (10) begin
      @(negedge iClock);
      if (oStepDone) cnt++;
    end
    check("busy_extra", cnt, 0);
    check("busy_idle", int'(oBusy), 0);
    check("busy_hx", int'(oHeadX), 24);

    // Loop back into the vacating tail cell (length 4)
    do_step(2'b10, 1'b0, lat, dead, ate, busy1);
    do_step(2'b11, 1'b0, lat, dead, ate, busy1);
    do_step(2'b00, 1'b0, lat, dead, ate, busy1);
    check("tail_lat", lat, 6);
    check("tail_dead", int'(oDead), 0);
    check("tail_hx", int'(oHeadX), 23);
    check("tail_hy", int'(oHeadY), 15);

    // Grow to 5 then steer into the body
    iFoodX = 6'd23; iFoodY = 5'd14;
    do_step(2'b00, 1'b0, lat, dead, ate, busy1);
    check("g5_lat", lat, 7);
    check("g5_len", int'(oLength), 5);
    iFoodX = 6'd0; iFoodY = 5'd0;
    do_step(2'b11, 1'b0, lat, dead, ate, busy1);
    do_step(2'b10, 1'b0, lat, dead, ate, busy1);
    check("g5_hx", int'(oHeadX), 22);
    check("g5_hy", int'(oHeadY), 15);
    do_step(2'b01, 1'b0, lat, dead, ate, busy1);
    check("body_dead", dead, 1);
    check("body_nodone", lat, 0);
    do_step(2'b01, 1'b0, lat, dead, ate, busy1);
    check("dead_busy", busy1, 0);
    check("dead_sticky", int'(oDead), 1);
    check("dead_hx", int'(oHeadX), 22);
    check("dead_len", int'(oLength), 5);

    // Reset in the middle of SCAN
    do_reset();
    @(posedge iClock); #1 iDir = 2'b01; iTick = 1'b1;
    @(posedge iClock); #1 iTick = 1'b0;
    @(posedge iClock); #1 iReset = 1'b1;
    check("mid_busy", int'(oBusy), 1);
    @(posedge iClock); #1 iReset = 1'b0;
    check("mid_hx", int'(oHeadX), 20);
    check("mid_len", int'(oLength), 3);
    check("mid_busy0", int'(oBusy), 0);
    check_seg("mid_seg1", 1, 19, 15);
    cnt = 0;
    repeat (10) begin
      @(negedge iClock);
      if (oStepDone) cnt++;
    end
    check("mid_nodone", cnt, 0);

    // Walk to the right wall
    for (int i = 0; i < 19; i++) do_step(2'b01, 1'b0, lat, dead, ate, busy1);
    check("wall_lat", lat, 5);
    check("wall_hx", int'(oHeadX), 39);
    do_step(2'b01, 1'b0, lat, dead, ate, busy1);
    check("wall_dead", dead, 1);
    check("wall_nodone", lat, 0);
    check("wall_hx2", int'(oHeadX), 39);

    // Walk to the top wall: decrement from 0 must not wrap
    do_reset();
    for (int i = 0; i < 15; i++) do_step(2'b00, 1'b0, lat, dead, ate, busy1);
    check("top_hy", int'(oHeadY), 0);
    check("top_alive", int'(oDead), 0);
    do_step(2'b00, 1'b0, lat, dead, ate, busy1);
    check("top_dead", dead, 1);
    check("top_hy2", int'(oHeadY), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
